// File: rtl/ddr_timing_checker.sv
// DDR4 command-bus timing checker. It decodes each command and tracks per-bank
// and global elapsed-cycle timers. It reports the lowest-numbered rule violated.
module ddr_timing_checker #(
    parameter int NUM_BG = 2,
    parameter int NUM_BA = 4,
    parameter int tRCD   = 15,
    parameter int tRP    = 15,
    parameter int tRAS   = 35,
    parameter int tRRD   = 4,
    parameter int tCCD   = 4,
    parameter int tWTR   = 3,
    parameter int tMRD   = 8,
    parameter int tMOD   = 24,
    parameter int CL     = 11,
    parameter int CWL    = 9,
    parameter int AL     = 0,
    parameter int BL     = 8,
    parameter int CNT_W  = 8,
    localparam int BG_W   = (NUM_BG > 1) ? $clog2(NUM_BG) : 1,
    localparam int BA_W   = (NUM_BA > 1) ? $clog2(NUM_BA) : 1,
    localparam int BANK_W = (NUM_BG * NUM_BA > 1) ? $clog2(NUM_BG * NUM_BA) : 1
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              RAS_n_A16,
    input  logic              CAS_n_A15,
    input  logic              WE_n_A14,
    input  logic [BG_W-1:0]   bg_addr,
    input  logic [BA_W-1:0]   ba_addr,
    output logic              viol_valid,
    output logic [3:0]        viol_code,
    output logic [BANK_W-1:0] viol_bank,
    output logic [15:0]       viol_count,
    output logic [15:0]       cmd_count
);

    localparam int NUM_BANKS = NUM_BG * NUM_BA;
    localparam logic [CNT_W-1:0] T_MAX = '1;
    localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);
    localparam int RCD_LIM   = tRCD - AL;
    localparam int WR2RD_LIM = CWL + BL / 2 + tWTR;
    localparam int RD2WR_LIM = CL + BL / 2 + 2 - CWL;

    typedef enum logic [3:0] {
        CMD_DES, CMD_ACT, CMD_MRS, CMD_REF, CMD_PRE,
        CMD_WR, CMD_RD, CMD_ZQ, CMD_NOP, CMD_RSVD
    } cmd_e;

    typedef enum logic {BANK_IDLE, BANK_OPEN} bank_state_e;

    cmd_e              cmd;
    logic [BANK_W-1:0] bank;
    bank_state_e       bank_state [NUM_BANKS];
    logic [CNT_W-1:0]  since_act [NUM_BANKS];
    logic [CNT_W-1:0]  since_pre [NUM_BANKS];
    logic [CNT_W-1:0]  since_act_any, since_rd, since_wr, since_cas, since_mrs;
    logic [CNT_W-1:0]  bank_since_act, bank_since_pre;
    logic              any_open, bank_open, is_cas, is_checked;
    logic [3:0]        code_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] t);
        return (t == T_MAX) ? t : t + T_ONE;
    endfunction

    function automatic logic below(input logic [CNT_W-1:0] t, input int lim);
        return int'(t) < lim;
    endfunction

    // NOTE: every signal written in a combinational block gets a default on
    // its first line, so no path through the block can infer a latch.
    always_comb begin
        cmd = CMD_DES;
        if (!cs_n) begin
            if (!act_n) begin
                cmd = CMD_ACT;
            end else begin
                case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
                    3'b000:  cmd = CMD_MRS;
                    3'b001:  cmd = CMD_REF;
                    3'b010:  cmd = CMD_PRE;
                    3'b100:  cmd = CMD_WR;
                    3'b101:  cmd = CMD_RD;
                    3'b110:  cmd = CMD_ZQ;
                    3'b111:  cmd = CMD_NOP;
                    default: cmd = CMD_RSVD;
                endcase
            end
        end
    end

    assign bank           = BANK_W'(int'(bg_addr) * NUM_BA + int'(ba_addr));
    assign bank_open      = (bank_state[bank] == BANK_OPEN);
    assign bank_since_act = since_act[bank];
    assign bank_since_pre = since_pre[bank];
    assign is_cas         = (cmd == CMD_RD) || (cmd == CMD_WR);
    assign is_checked     = enable && (cmd != CMD_DES);

    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            any_open |= (bank_state[b] == BANK_OPEN);
        end
    end

    // Checks run from the highest code down, so the lowest failing code wins.
    always_comb begin
        code_next = 4'd0;
        if (is_checked) begin
            if (cmd == CMD_REF && any_open)                            code_next = 4'd12;
            if (cmd != CMD_MRS && below(since_mrs, tMOD))              code_next = 4'd11;
            if (cmd == CMD_MRS && below(since_mrs, tMRD))              code_next = 4'd10;
            if (cmd == CMD_WR && below(since_rd, RD2WR_LIM))           code_next = 4'd9;
            if (cmd == CMD_RD && below(since_wr, WR2RD_LIM))           code_next = 4'd8;
            if (is_cas && below(since_cas, tCCD))                      code_next = 4'd7;
            if (cmd == CMD_PRE && bank_open && below(bank_since_act, tRAS)) code_next = 4'd6;
            if (is_cas && below(bank_since_act, RCD_LIM))              code_next = 4'd5;
            if (is_cas && !bank_open)                                  code_next = 4'd4;
            if (cmd == CMD_ACT && below(since_act_any, tRRD))          code_next = 4'd3;
            if (cmd == CMD_ACT && below(bank_since_pre, tRP))          code_next = 4'd2;
            if (cmd == CMD_ACT && bank_open)                           code_next = 4'd1;
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            // NOTE: the per-bank arrays are plain flops, not a RAM, and are
            // reset so every bank starts IDLE with saturated timers.
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= BANK_IDLE;
                since_act[b]  <= T_MAX;
                since_pre[b]  <= T_MAX;
            end
            since_act_any <= T_MAX;
            since_rd      <= T_MAX;
            since_wr      <= T_MAX;
            since_cas     <= T_MAX;
            since_mrs     <= T_MAX;
            viol_valid    <= 1'b0;
            viol_code     <= 4'd0;
            viol_bank     <= '0;
            viol_count    <= 16'd0;
            cmd_count     <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments throughout; a command's timer load
            // further down overrides the default increment for that timer.
            for (int b = 0; b < NUM_BANKS; b++) begin
                since_act[b] <= sat_inc(since_act[b]);
                since_pre[b] <= sat_inc(since_pre[b]);
            end
            since_act_any <= sat_inc(since_act_any);
            since_rd      <= sat_inc(since_rd);
            since_wr      <= sat_inc(since_wr);
            since_cas     <= sat_inc(since_cas);
            since_mrs     <= sat_inc(since_mrs);
            viol_valid    <= 1'b0;
            viol_code     <= 4'd0;
            viol_bank     <= '0;

            if (is_checked) begin
                if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
                if (code_next != 4'd0) begin
                    viol_valid <= 1'b1;
                    viol_code  <= code_next;
                    viol_bank  <= bank;
                    if (viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
                end
                case (cmd)
                    CMD_ACT: begin
                        bank_state[bank] <= BANK_OPEN;
                        since_act[bank]  <= T_ONE;
                        since_act_any    <= T_ONE;
                    end
                    CMD_PRE: begin
                        if (bank_open) begin
                            bank_state[bank] <= BANK_IDLE;
                            since_pre[bank]  <= T_ONE;
                        end
                    end
                    CMD_RD: begin
                        since_rd  <= T_ONE;
                        since_cas <= T_ONE;
                    end
                    CMD_WR: begin
                        since_wr  <= T_ONE;
                        since_cas <= T_ONE;
                    end
                    CMD_MRS: since_mrs <= T_ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_timing_checker.sv
// Bench for ddr_timing_checker: a directed vector table, hand-written corner sequences,
// and random traffic checked against a timestamp-based reference model.
module tb_ddr_timing_checker;

    localparam int NUM_BG = 2;
    localparam int NUM_BA = 4;
    localparam int tRCD = 15, tRP = 15, tRAS = 35, tRRD = 4, tCCD = 4, tWTR = 3;
    localparam int tMRD = 8, tMOD = 24, CL = 11, CWL = 9, AL = 0, BL = 8, CNT_W = 8;
    localparam int NB     = NUM_BG * NUM_BA;
    localparam int BG_W   = $clog2(NUM_BG);
    localparam int BA_W   = $clog2(NUM_BA);
    localparam int BANK_W = $clog2(NB);
    localparam int TMAX   = (1 << CNT_W) - 1;
    localparam int NEVER  = -1000000;

    typedef enum int {C_DES, C_ACT, C_MRS, C_REF, C_PRE, C_WR, C_RD, C_ZQ, C_NOP} cmd_e;

    typedef struct {
        cmd_e cmd;
        int   bg;
        int   ba;
        int   dly;      // cycles since the previous table command
        bit   en;
        int   exp_code; // 0 = no violation expected
    } vec_t;

    logic              CK_t = 1'b0;
    logic              reset_n, enable, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [BG_W-1:0]   bg_addr;
    logic [BA_W-1:0]   ba_addr;
    logic              viol_valid;
    logic [3:0]        viol_code;
    logic [BANK_W-1:0] viol_bank;
    logic [15:0]       viol_count, cmd_count;

    always #5 CK_t = ~CK_t;

    ddr_timing_checker #(
        .NUM_BG(NUM_BG), .NUM_BA(NUM_BA), .tRCD(tRCD), .tRP(tRP), .tRAS(tRAS),
        .tRRD(tRRD), .tCCD(tCCD), .tWTR(tWTR), .tMRD(tMRD), .tMOD(tMOD),
        .CL(CL), .CWL(CWL), .AL(AL), .BL(BL), .CNT_W(CNT_W)
    ) dut (
        .CK_t(CK_t), .reset_n(reset_n), .enable(enable), .cs_n(cs_n), .act_n(act_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .bg_addr(bg_addr), .ba_addr(ba_addr), .viol_valid(viol_valid),
        .viol_code(viol_code), .viol_bank(viol_bank), .viol_count(viol_count),
        .cmd_count(cmd_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the cycle number of each relevant event.
    int cyc;
    int m_last_act [NB];
    int m_last_pre [NB];
    bit m_open [NB];
    int m_last_act_any, m_last_rd, m_last_wr, m_last_cas, m_last_mrs;
    bit m_valid;
    int m_code, m_bank, m_vcnt, m_ccnt;

    function automatic int since(input int last);
        int g;
        g = cyc - last;
        return (g > TMAX) ? TMAX : g;
    endfunction

    task automatic model_reset();
        foreach (m_open[i]) begin
            m_open[i]     = 1'b0;
            m_last_act[i] = NEVER;
            m_last_pre[i] = NEVER;
        end
        m_last_act_any = NEVER;
        m_last_rd      = NEVER;
        m_last_wr      = NEVER;
        m_last_cas     = NEVER;
        m_last_mrs     = NEVER;
        m_vcnt         = 0;
        m_ccnt         = 0;
    endtask

    task automatic model_step(input cmd_e c, input int b, input bit en, input bit rst);
        int codes[$];
        bit any_open;
        m_valid  = 1'b0;
        m_code   = 0;
        m_bank   = 0;
        any_open = 1'b0;
        foreach (m_open[i]) any_open |= m_open[i];
        if (!rst) begin
            model_reset();
        end else if (en && c != C_DES) begin
            if (m_ccnt < 65535) m_ccnt++;
            if (c == C_ACT && m_open[b])                          codes.push_back(1);
            if (c == C_ACT && since(m_last_pre[b]) < tRP)         codes.push_back(2);
            if (c == C_ACT && since(m_last_act_any) < tRRD)       codes.push_back(3);
            if ((c == C_RD || c == C_WR) && !m_open[b])           codes.push_back(4);
            if ((c == C_RD || c == C_WR) && since(m_last_act[b]) < tRCD - AL) codes.push_back(5);
            if (c == C_PRE && m_open[b] && since(m_last_act[b]) < tRAS) codes.push_back(6);
            if ((c == C_RD || c == C_WR) && since(m_last_cas) < tCCD) codes.push_back(7);
            if (c == C_RD && since(m_last_wr) < CWL + BL / 2 + tWTR) codes.push_back(8);
            if (c == C_WR && since(m_last_rd) < CL + BL / 2 + 2 - CWL) codes.push_back(9);
            if (c == C_MRS && since(m_last_mrs) < tMRD)           codes.push_back(10);
            if (c != C_MRS && since(m_last_mrs) < tMOD)           codes.push_back(11);
            if (c == C_REF && any_open)                           codes.push_back(12);
            if (codes.size() > 0) begin
                m_valid = 1'b1;
                m_code  = codes[0];
                foreach (codes[i]) if (codes[i] < m_code) m_code = codes[i];
                m_bank  = b;
                if (m_vcnt < 65535) m_vcnt++;
            end
            case (c)
                C_ACT: begin m_open[b] = 1'b1; m_last_act[b] = cyc; m_last_act_any = cyc; end
                C_PRE: if (m_open[b]) begin m_open[b] = 1'b0; m_last_pre[b] = cyc; end
                C_RD:  begin m_last_rd = cyc; m_last_cas = cyc; end
                C_WR:  begin m_last_wr = cyc; m_last_cas = cyc; end
                C_MRS: m_last_mrs = cyc;
                default: ;
            endcase
        end
        cyc++;
    endtask

    // Drive one command for one clock; outputs reflecting it are valid on return.
    task automatic apply(input cmd_e c, input int bg, input int ba, input bit en, input bit rst);
        logic [4:0] pins;
        logic [3:0] junk;
        junk = 4'($urandom);
        case (c)
            C_DES:   pins = {1'b1, junk};
            C_ACT:   pins = {2'b00, junk[2:0]};
            C_MRS:   pins = 5'b01000;
            C_REF:   pins = 5'b01001;
            C_PRE:   pins = 5'b01010;
            C_WR:    pins = 5'b01100;
            C_RD:    pins = 5'b01101;
            C_ZQ:    pins = 5'b01110;
            default: pins = 5'b01111;
        endcase
        {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = pins;
        bg_addr = BG_W'(bg);
        ba_addr = BA_W'(ba);
        enable  = en;
        reset_n = rst;
        model_step(c, bg * NUM_BA + ba, en, rst);
        @(negedge CK_t);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".viol_valid"}, viol_valid, m_valid);
        check({tag, ".viol_code"},  viol_code,  m_code);
        check({tag, ".viol_bank"},  viol_bank,  m_bank);
        check({tag, ".viol_count"}, viol_count, m_vcnt);
        check({tag, ".cmd_count"},  cmd_count,  m_ccnt);
    endtask

    function automatic vec_t mk(input cmd_e c, input int bg, input int ba,
                                input int dly, input bit en, input int code);
        vec_t v;
        v.cmd = c; v.bg = bg; v.ba = ba; v.dly = dly; v.en = en; v.exp_code = code;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv[$];
        int   exp_viols, exp_cmds;

        cyc = 0;
        model_reset();
        apply(C_DES, 0, 0, 1'b1, 1'b0);
        apply(C_DES, 0, 0, 1'b1, 1'b0);
        check("reset.viol_valid", viol_valid, 0);
        check("reset.viol_code",  viol_code,  0);
        check("reset.viol_bank",  viol_bank,  0);
        check("reset.viol_count", viol_count, 0);
        check("reset.cmd_count",  cmd_count,  0);

        // Directed table: expected codes worked out by hand from the timing rules.
        tv.push_back(mk(C_ACT, 0, 0,  1, 1, 0));  // t=0
        tv.push_back(mk(C_RD,  0, 0, 15, 1, 0));  // tRCD met exactly
        tv.push_back(mk(C_PRE, 0, 0, 20, 1, 0));  // tRAS met exactly
        tv.push_back(mk(C_ACT, 0, 0, 15, 1, 0));  // tRP met exactly
        tv.push_back(mk(C_RD,  0, 0, 14, 1, 5));  // tRCD short by one
        tv.push_back(mk(C_PRE, 0, 0, 26, 1, 0));
        tv.push_back(mk(C_ACT, 1, 2, 20, 1, 0));
        tv.push_back(mk(C_ACT, 0, 0,  3, 1, 3));  // tRRD short
        tv.push_back(mk(C_PRE, 1, 2, 37, 1, 0));
        tv.push_back(mk(C_PRE, 0, 0,  1, 1, 0));
        tv.push_back(mk(C_ACT, 1, 2, 19, 1, 0));
        tv.push_back(mk(C_ACT, 0, 0,  4, 1, 0));  // tRRD met exactly
        tv.push_back(mk(C_WR,  0, 0, 26, 1, 0));
        tv.push_back(mk(C_RD,  0, 0, 15, 1, 8));  // write-to-read short
        tv.push_back(mk(C_WR,  0, 0, 25, 1, 0));
        tv.push_back(mk(C_RD,  0, 0, 16, 1, 0));  // write-to-read met exactly
        tv.push_back(mk(C_WR,  0, 0,  7, 1, 9));  // read-to-write short
        tv.push_back(mk(C_RD,  0, 0,  3, 1, 7));  // codes 7 and 8 both fail
        tv.push_back(mk(C_ACT, 0, 3, 14, 1, 0));
        tv.push_back(mk(C_ACT, 0, 3, 40, 1, 1));  // ACT to open bank
        tv.push_back(mk(C_PRE, 0, 3, 10, 1, 6));  // timer reloaded by violating ACT
        tv.push_back(mk(C_MRS, 0, 0, 20, 1, 0));
        tv.push_back(mk(C_MRS, 0, 0,  7, 1, 10));
        tv.push_back(mk(C_ACT, 0, 1, 23, 1, 11));
        tv.push_back(mk(C_ACT, 1, 1, 40, 1, 0));
        tv.push_back(mk(C_REF, 1, 1, 10, 1, 12));
        tv.push_back(mk(C_ACT, 1, 1,  1, 0, 0));  // disabled: ignored
        tv.push_back(mk(C_PRE, 0, 2,  9, 1, 0));  // PRE to idle bank
        tv.push_back(mk(C_ACT, 0, 2,  1, 1, 0));  // tRP timer untouched by it

        exp_viols = 0;
        exp_cmds  = 0;
        foreach (tv[i]) begin
            for (int k = 1; k < tv[i].dly; k++) begin
                apply(C_DES, 0, 0, 1'b1, 1'b1);
                if (k == 1) check($sformatf("tbl[%0d].quiet", i), {viol_valid, viol_code, viol_bank}, 0);
            end
            apply(tv[i].cmd, tv[i].bg, tv[i].ba, tv[i].en, 1'b1);
            check($sformatf("tbl[%0d].viol_valid", i), viol_valid, tv[i].exp_code != 0);
            check($sformatf("tbl[%0d].viol_code", i), viol_code, tv[i].exp_code);
            if (tv[i].exp_code != 0) begin
                check($sformatf("tbl[%0d].viol_bank", i), viol_bank, tv[i].bg * NUM_BA + tv[i].ba);
                exp_viols++;
            end
            if (tv[i].en) exp_cmds++;
        end
        check("tbl.viol_count", viol_count, exp_viols);
        check("tbl.cmd_count",  cmd_count,  exp_cmds);

        // Reset mid-stream with banks open; the ACT in the reset cycle is ignored.
        apply(C_ACT, 0, 0, 1'b1, 1'b0);
        check("rst_mid.viol_valid", viol_valid, 0);
        check("rst_mid.viol_count", viol_count, 0);
        check("rst_mid.cmd_count",  cmd_count,  0);
        apply(C_ACT, 0, 0, 1'b1, 1'b1);
        check("post_rst.act_valid", viol_valid, 0);
        apply(C_RD, 1, 2, 1'b1, 1'b1);
        check("post_rst.rd_valid", viol_valid, 1);
        check("post_rst.rd_code",  viol_code,  4);
        check("post_rst.rd_bank",  viol_bank,  6);
        check("post_rst.viol_count", viol_count, 1);
        check("post_rst.cmd_count",  cmd_count,  2);
        apply(C_DES, 0, 0, 1'b1, 1'b1);
        check("pulse.one_cycle", {viol_valid, viol_code, viol_bank}, 0);

        // Illegal ACT while disabled, then the same ACT enabled.
        apply(C_ACT, 0, 0, 1'b0, 1'b1);
        check("dis.viol_valid", viol_valid, 0);
        check("dis.cmd_count",  cmd_count,  2);
        check("dis.viol_count", viol_count, 1);
        apply(C_ACT, 0, 0, 1'b1, 1'b1);
        check("reen.viol_code", viol_code, 1);
        check("reen.viol_bank", viol_bank, 0);
        check("reen.cmd_count", cmd_count, 3);

        // Random traffic against the reference model.
        apply(C_DES, 0, 0, 1'b1, 1'b0);
        check_model("rnd_rst");
        for (int n = 0; n < 4000; n++) begin
            int   r;
            cmd_e c;
            bit   en, rst;
            r   = $urandom_range(0, 199);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 599) != 0);
            if      (r < 70)  c = C_DES;
            else if (r < 110) c = C_ACT;
            else if (r < 140) c = C_PRE;
            else if (r < 160) c = C_RD;
            else if (r < 180) c = C_WR;
            else if (r < 181) c = C_MRS;
            else if (r < 186) c = C_REF;
            else if (r < 193) c = C_ZQ;
            else              c = C_NOP;
            apply(c, $urandom_range(0, NUM_BG - 1), $urandom_range(0, NUM_BA - 1), en, rst);
            check_model($sformatf("rnd[%0d]", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
